// File: rtl/lgu_pkg.sv
// Shared types for the logic/shift unit writeback path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lgu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  // One buffered result, exactly as produced by the logic/shift unit.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              z;
    logic              n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              flag_en;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_EMPTY,
    WB_HALF,
    WB_FULL
  } wb_state_t;

endpackage

// File: rtl/lgu_skid_buf.sv
// 2-entry skid buffer of wb_entry_t: head register plus one skid slot, FIFO order.
// Latency: 1 cycle from accept to o_vld; full rate of 1 entry/cycle when drained every cycle.
// Backpressure: o_rdy is decoded from state only (low in FULL); flush empties both slots.
module lgu_skid_buf
  import lgu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      i_vld,
  input  wb_entry_t i_entry,
  output logic      o_rdy,
  output logic      o_vld,
  input  logic      i_rdy,
  output wb_entry_t o_head
);

  wb_state_t r_state, w_state_nxt;
  wb_entry_t r_head,  w_head_nxt;
  wb_entry_t r_skid,  w_skid_nxt;
  logic      w_accept;
  logic      w_retire;

  assign o_rdy    = (r_state != WB_FULL);
  assign o_vld    = (r_state != WB_EMPTY);
  assign o_head   = r_head;
  assign w_accept = i_vld & o_rdy;
  assign w_retire = o_vld & i_rdy;

  // Next state and slot contents; flush drops everything, including a same-cycle accept.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = WB_EMPTY;
      w_head_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        WB_EMPTY: begin
          if (w_accept) begin
            w_head_nxt  = i_entry;
            w_state_nxt = WB_HALF;
          end
        end
        WB_HALF: begin
          if (w_accept && !w_retire) begin
            w_skid_nxt  = i_entry;
            w_state_nxt = WB_FULL;
          end else if (w_retire && !w_accept) begin
            w_state_nxt = WB_EMPTY;
          end else if (w_accept && w_retire) begin
            w_head_nxt  = i_entry;
          end
        end
        WB_FULL: begin
          if (w_retire) begin
            w_head_nxt  = r_skid;
            w_state_nxt = WB_HALF;
          end
        end
        default: begin
          w_state_nxt = WB_EMPTY;
        end
      endcase
    end
  end

  // State and slot registers; reset wins over flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WB_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

endmodule

// File: rtl/lgu_wb_stage.sv
// Writeback stage after the logic/shift unit: buffers results, drives RF write, owns Z/N flags.
// Latency: 1 cycle in_valid to out_valid; flags update the cycle after an entry retires.
// Backpressure: 2-entry skid buffer; in_ready drops only when both slots are occupied.
module lgu_wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_z,
  input  logic              in_n,
  input  logic              in_wr_en,
  input  logic [ADDR_W-1:0] in_wr_addr,
  input  logic              in_flag_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic              flag_z,
  output logic              flag_n
);

  import lgu_pkg::*;

  wb_entry_t w_in_entry;
  wb_entry_t w_head;
  logic      w_out_vld;
  logic      w_retire;
  logic      r_flag_z;
  logic      r_flag_n;

  // Flags are captured verbatim from the unit; nothing is recomputed here.
  assign w_in_entry.data    = in_data;
  assign w_in_entry.z       = in_z;
  assign w_in_entry.n       = in_n;
  assign w_in_entry.wr_en   = in_wr_en;
  assign w_in_entry.wr_addr = in_wr_addr;
  assign w_in_entry.flag_en = in_flag_en;

  lgu_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_vld   (in_valid),
    .i_entry (w_in_entry),
    .o_rdy   (in_ready),
    .o_vld   (w_out_vld),
    .i_rdy   (out_ready),
    .o_head  (w_head)
  );

  // A retire in the flush cycle is a real transfer, so it still commits its flags.
  assign w_retire = w_out_vld & out_ready;

  // Architectural Z/N: only retiring entries with flag_en touch them; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_z <= 1'b1;
      r_flag_n <= 1'b0;
    end else if (w_retire && w_head.flag_en) begin
      r_flag_z <= w_head.z;
      r_flag_n <= w_head.n;
    end
  end

  assign out_valid   = w_out_vld;
  assign out_data    = w_head.data;
  assign out_wr_en   = w_out_vld & w_head.wr_en;
  assign out_wr_addr = w_head.wr_addr;
  assign flag_z      = r_flag_z;
  assign flag_n      = r_flag_n;

endmodule

// File: tb/tb_lgu_wb_stage.sv
// Self-checking bench for lgu_wb_stage against a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_lgu_wb_stage;

  typedef struct {
    logic [15:0] data;
    logic        z;
    logic        n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic        flag_en;
  } tb_entry_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_z;
  logic        in_n;
  logic        in_wr_en;
  logic [2:0]  in_wr_addr;
  logic        in_flag_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_wr_en;
  logic [2:0]  out_wr_addr;
  logic        flag_z;
  logic        flag_n;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: an ordered queue of at most two entries plus the flag pair.
  tb_entry_t mq[$];
  logic      m_fz;
  logic      m_fn;

  lgu_wb_stage #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_z        (in_z),
    .in_n        (in_n),
    .in_wr_en    (in_wr_en),
    .in_wr_addr  (in_wr_addr),
    .in_flag_en  (in_flag_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_wr_en   (out_wr_en),
    .out_wr_addr (out_wr_addr),
    .flag_z      (flag_z),
    .flag_n      (flag_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic tb_entry_t mk(input logic [15:0] d, input logic z, input logic n,
                                   input logic we, input logic [2:0] a, input logic fe);
    tb_entry_t e;
    e.data = d; e.z = z; e.n = n; e.wr_en = we; e.wr_addr = a; e.flag_en = fe;
    return e;
  endfunction

  task automatic drive(input tb_entry_t e, input logic v);
    in_valid   = v;
    in_data    = e.data;
    in_z       = e.z;
    in_n       = e.n;
    in_wr_en   = e.wr_en;
    in_wr_addr = e.wr_addr;
    in_flag_en = e.flag_en;
  endtask

  // One clock: apply the model's rules for the current inputs, then return at the negedge.
  task automatic tick();
    tb_entry_t cur;
    bit acc;
    bit ret;
    cur = mk(in_data, in_z, in_n, in_wr_en, in_wr_addr, in_flag_en);
    acc = in_valid && (mq.size() < 2);
    ret = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_fz = 1'b1;
      m_fn = 1'b0;
    end else begin
      if (ret) begin
        if (mq[0].flag_en) begin
          m_fz = mq[0].z;
          m_fn = mq[0].n;
        end
        void'(mq.pop_front());
      end
      if (flush) mq.delete();
      else if (acc) mq.push_back(cur);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(mk(16'h1234, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1), 1'b1);
    tick(); tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if ({flag_z, flag_n} !== 2'b10) $display("FAIL reset_flags got z%b n%b want z1 n0", flag_z, flag_n); else n_pass++;
    n_total++; if (out_data !== 16'h0 || out_wr_en !== 1'b0 || out_wr_addr !== 3'd0)
      $display("FAIL reset_out_fields got %h/%b/%0d want 0000/0/0", out_data, out_wr_en, out_wr_addr); else n_pass++;
    rst = 1'b0;
    drive(mk(16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0);
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_nothing_captured got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(mk(16'h8000, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1), 1'b1);
    tick();
    drive(mk(16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0);
    n_total++; if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_wr_addr !== 3'd5 || out_wr_en !== 1'b1)
      $display("FAIL single_out got v%b %h a%0d we%b want v1 8000 a5 we1", out_valid, out_data, out_wr_addr, out_wr_en); else n_pass++;
    n_total++; if ({flag_z, flag_n} !== 2'b10) $display("FAIL single_no_flag_on_accept got z%b n%b want z1 n0", flag_z, flag_n); else n_pass++;
    tick();
    n_total++; if ({flag_z, flag_n} !== 2'b01) $display("FAIL single_flags got z%b n%b want z0 n1", flag_z, flag_n); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_drained got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(mk(16'h0001, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0), 1'b1);
    tick();
    drive(mk(16'h0002, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0), 1'b1);
    tick();
    drive(mk(16'h0003, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0), 1'b0);
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got %b want 0", in_ready); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_data !== 16'h0001 || out_wr_addr !== 3'd1)
      $display("FAIL bp_head_stable got v%b %h a%0d want v1 0001 a1", out_valid, out_data, out_wr_addr); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b1 || out_data !== 16'h0002 || out_wr_addr !== 3'd2)
      $display("FAIL bp_second got v%b %h a%0d want v1 0002 a2", out_valid, out_data, out_wr_addr); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_half got %b want 1", in_ready); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_flag_gating();
    out_ready = 1'b1;
    drive(mk(16'h0000, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0), 1'b1);
    tick();
    drive(mk(16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0);
    n_total++; if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_wr_en !== 1'b1)
      $display("FAIL gate_written got v%b %h we%b want v1 0000 we1", out_valid, out_data, out_wr_en); else n_pass++;
    tick();
    n_total++; if ({flag_z, flag_n} !== 2'b01) $display("FAIL gate_flags_hold got z%b n%b want z0 n1", flag_z, flag_n); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(mk(16'h00AA, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1), 1'b1);
    tick();
    drive(mk(16'h00BB, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1), 1'b1);
    tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL flush_pre_full got %b want 0", in_ready); else n_pass++;
    flush = 1'b1;
    drive(mk(16'h00CC, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1), 1'b1);
    tick();
    flush = 1'b0;
    drive(mk(16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0);
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_empty got v%b r%b want v0 r1", out_valid, in_ready); else n_pass++;
    n_total++; if ({flag_z, flag_n} !== 2'b01) $display("FAIL flush_flags_kept got z%b n%b want z0 n1", flag_z, flag_n); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_input_dropped got %b want 0", out_valid); else n_pass++;
    // A retire that coincides with flush still commits its flags.
    out_ready = 1'b0;
    drive(mk(16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1), 1'b1);
    tick();
    drive(mk(16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0);
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_total++; if ({flag_z, flag_n, out_valid} !== 3'b100)
      $display("FAIL flush_retire_commits got z%b n%b v%b want z1 n0 v0", flag_z, flag_n, out_valid); else n_pass++;
  endtask

  task automatic test_stream();
    int sent = 0;
    int retired = 0;
    int cyc = 0;
    int errs = 0;
    tb_entry_t e;
    while (retired < 100 && cyc < 3000) begin
      e = mk(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
      drive(e, sent < 100);
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready !== (mq.size() < 2)) errs++;
      if (out_valid !== (mq.size() > 0)) errs++;
      else if (out_valid && (out_data !== mq[0].data || out_wr_addr !== mq[0].wr_addr || out_wr_en !== mq[0].wr_en)) errs++;
      if (flag_z !== m_fz || flag_n !== m_fn) errs++;
      if (errs != 0 && n_total >= 0) begin
        n_total++;
        $display("FAIL stream_cycle%0d got v%b %h a%0d z%b n%b want q%0d z%b n%b", cyc, out_valid, out_data,
                 out_wr_addr, flag_z, flag_n, mq.size(), m_fz, m_fn);
        errs = 0;
      end
      if (out_valid === 1'b1 && out_ready) retired++;
      if (sent < 100 && mq.size() < 2) sent++;
      tick();
      cyc++;
    end
    drive(mk(16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0);
    n_total++; if (retired !== 100) $display("FAIL stream_count got %0d want 100", retired); else n_pass++;
    n_total++; if (out_valid !== 1'b0 || mq.size() != 0)
      $display("FAIL stream_drained got v%b q%0d want v0 q0", out_valid, mq.size()); else n_pass++;
    n_total++; if (flag_z !== m_fz || flag_n !== m_fn)
      $display("FAIL stream_final_flags got z%b n%b want z%b n%b", flag_z, flag_n, m_fz, m_fn); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(mk(16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0);
    m_fz = 1'b1; m_fn = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_flag_gating();
    test_flush();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
